spi_master_nch: RTL and testbench

- Parametrised, multi-chip-select SPI master (mode 0: CPOL=0, CPHA=0) with a runtime-programmable packet length and SCLK divider.
- Takes a parallel word on a val/rdy receive interface and shifts it out MSB-first on MOSI. Simultaneously samples MISO and returns the captured word on a val/rdy send interface.
- Sits between the processor/streaming fabric and off-chip SPI peripherals. Drives up to ncs independent active-low chip selects.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 32 +++
 rtl/spi_master_nch.sv | 165 ++++++++++++++++
 tb/tb_spi_master_nch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and width helpers for the mode-0 SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SCLK_LOW,
        SCLK_HIGH,
        CS_HOLD,
        DONE
    } state_e;

    function automatic int psize_w(input int nbits);
        return $clog2(nbits) + 1;
    endfunction

    function automatic int csaddr_w(input int ncs);
        return (ncs > 1) ? $clog2(ncs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: reloads with D on each phase entry, flags the last cycle of the phase.
module spi_clk_div #(
    parameter int divw = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            active,
    input  logic [divw-1:0] div,
    output logic            phase_done
);

    logic [divw-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = div;
        else if (cnt_q != '0)
            cnt_d = cnt_q - divw'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign phase_done = active && (cnt_q == '0);

endmodule

// File: rtl/spi_master_nch.sv
// Mode-0 SPI master with runtime packet length, SCLK divider and chip-select index.
module spi_master_nch
    import spi_pkg::*;
#(
    parameter int nbits = 34,
    parameter int ncs   = 4,
    parameter int divw  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         packet_size_ifc_val,
    output logic                         packet_size_ifc_rdy,
    input  logic [psize_w(nbits)-1:0]    packet_size_ifc_msg,
    input  logic                         cs_addr_ifc_val,
    output logic                         cs_addr_ifc_rdy,
    input  logic [csaddr_w(ncs)-1:0]     cs_addr_ifc_msg,
    input  logic                         freq_ifc_val,
    output logic                         freq_ifc_rdy,
    input  logic [divw-1:0]              freq_ifc_msg,
    input  logic                         recv_val,
    output logic                         recv_rdy,
    input  logic [nbits-1:0]             recv_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [nbits-1:0]             send_msg,
    output logic [ncs-1:0]               cs,
    output logic                         sclk,
    output logic                         mosi,
    input  logic                         miso
);

    localparam int PSW = psize_w(nbits);
    localparam int CSW = csaddr_w(ncs);
    localparam logic [PSW-1:0] NBITS_P = PSW'(nbits);

    state_e           state_q, state_d;
    logic [PSW-1:0]   psize_q, psize_d, act_psize_q, act_psize_d;
    logic [CSW-1:0]   csaddr_q, csaddr_d, act_cs_q, act_cs_d;
    logic [divw-1:0]  div_q, div_d, act_div_q, act_div_d;
    logic [nbits-1:0] tx_q, tx_d, rx_q, rx_d, tx_shr;
    logic [PSW-1:0]   cnt_q, cnt_d, pidx;
    logic [ncs-1:0]   cs_q, cs_d;
    logic             sclk_q, sclk_d, mosi_q, mosi_d, send_val_q, send_val_d;
    logic             idle, phase_done, div_load, div_active, active_d;

    assign idle = (state_q == IDLE) && !reset;
    assign recv_rdy            = idle;
    assign packet_size_ifc_rdy = idle;
    assign cs_addr_ifc_rdy     = idle;
    assign freq_ifc_rdy        = idle;

    assign div_active = (state_q == SCLK_LOW) || (state_q == SCLK_HIGH);
    assign div_load   = (state_d != state_q) && ((state_d == SCLK_LOW) || (state_d == SCLK_HIGH));

    spi_clk_div #(.divw(divw)) u_clk_div (
        .clk        (clk),
        .reset      (reset),
        .load       (div_load),
        .active     (div_active),
        .div        (act_div_q),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d     = state_q;
        psize_d     = psize_q;
        csaddr_d    = csaddr_q;
        div_d       = div_q;
        act_psize_d = act_psize_q;
        act_cs_d    = act_cs_q;
        act_div_d   = act_div_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (packet_size_ifc_val)
                    psize_d = (packet_size_ifc_msg == '0 || packet_size_ifc_msg > NBITS_P)
                              ? NBITS_P : packet_size_ifc_msg;
                if (cs_addr_ifc_val) csaddr_d = cs_addr_ifc_msg;
                if (freq_ifc_val)    div_d    = freq_ifc_msg;
                // Snapshot the pre-edge config so a simultaneous config write only affects later packets.
                if (recv_val) begin
                    act_psize_d = psize_q;
                    act_cs_d    = csaddr_q;
                    act_div_d   = div_q;
                    tx_d        = recv_msg;
                    rx_d        = '0;
                    cnt_d       = '0;
                    state_d     = CS_SETUP;
                end
            end
            CS_SETUP: state_d = SCLK_LOW;
            SCLK_LOW: begin
                if (phase_done) begin
                    rx_d    = {rx_q[nbits-2:0], miso};
                    state_d = SCLK_HIGH;
                end
            end
            SCLK_HIGH: begin
                if (phase_done) begin
                    tx_d    = tx_q << 1;
                    cnt_d   = cnt_q + PSW'(1);
                    state_d = (cnt_d == act_psize_q) ? CS_HOLD : SCLK_LOW;
                end
            end
            CS_HOLD: state_d = DONE;
            DONE:    if (send_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so pins change cleanly on clock edges.
        active_d   = (state_d == CS_SETUP) || (state_d == SCLK_LOW) ||
                     (state_d == SCLK_HIGH) || (state_d == CS_HOLD);
        sclk_d     = (state_d == SCLK_HIGH);
        send_val_d = (state_d == DONE);
        pidx       = act_psize_d - PSW'(1);
        tx_shr     = tx_d >> pidx;
        mosi_d     = ((state_d == CS_SETUP) || (state_d == SCLK_LOW) || (state_d == SCLK_HIGH))
                     ? tx_shr[0] : 1'b0;
        for (int i = 0; i < ncs; i++)
            cs_d[i] = !(active_d && (int'(act_cs_d) == i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            psize_q     <= NBITS_P;
            csaddr_q    <= '0;
            div_q       <= '0;
            act_psize_q <= NBITS_P;
            act_cs_q    <= '0;
            act_div_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            cs_q        <= '1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            send_val_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            psize_q     <= psize_d;
            csaddr_q    <= csaddr_d;
            div_q       <= div_d;
            act_psize_q <= act_psize_d;
            act_cs_q    <= act_cs_d;
            act_div_q   <= act_div_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            send_val_q  <= send_val_d;
        end
    end

    assign cs       = cs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign send_val = send_val_q;
    assign send_msg = rx_q;

endmodule

// File: tb/tb_spi_master_nch.sv
// Randomised bench for spi_master_nch against a packet-level model of the SPI transfer.
module tb_spi_master_nch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_val, csa_val, fq_val, recv_val, send_rdy;
    logic [6:0]  ps_msg;
    logic [2:0]  csa_msg;
    logic [7:0]  fq_msg;
    logic [33:0] recv_msg;
    logic        loop_en, miso_const, miso;

    logic        ps_rdy, csa_rdy, fq_rdy, recv_rdy, send_val, sclk, mosi;
    logic [33:0] send_msg;
    logic [3:0]  cs;
    logic        ps_rdy5, csa_rdy5, fq_rdy5, recv_rdy5, send_val5, sclk5, mosi5;
    logic [33:0] send_msg5;
    logic [4:0]  cs5;

    int n_chk = 0;
    int n_fail = 0;

    int          o_lat, o_rises, o_high, o_low, o_cs_err, o_cs5_err, o_hold_err, o_io_err;
    logic [33:0] o_mosi, o_msg, o_msg5;
    bit          o_rdy_after, o_val5, o_timeout;

    always #5 clk = ~clk;
    assign miso = loop_en ? mosi : miso_const;

    spi_master_nch #(.nbits(34), .ncs(4), .divw(8)) dut (
        .clk(clk), .reset(reset),
        .packet_size_ifc_val(ps_val), .packet_size_ifc_rdy(ps_rdy), .packet_size_ifc_msg(ps_msg),
        .cs_addr_ifc_val(csa_val), .cs_addr_ifc_rdy(csa_rdy), .cs_addr_ifc_msg(csa_msg[1:0]),
        .freq_ifc_val(fq_val), .freq_ifc_rdy(fq_rdy), .freq_ifc_msg(fq_msg),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    // Five-select copy so an address of 5 is representable and out of range.
    spi_master_nch #(.nbits(34), .ncs(5), .divw(8)) dut5 (
        .clk(clk), .reset(reset),
        .packet_size_ifc_val(ps_val), .packet_size_ifc_rdy(ps_rdy5), .packet_size_ifc_msg(ps_msg),
        .cs_addr_ifc_val(csa_val), .cs_addr_ifc_rdy(csa_rdy5), .cs_addr_ifc_msg(csa_msg),
        .freq_ifc_val(fq_val), .freq_ifc_rdy(fq_rdy5), .freq_ifc_msg(fq_msg),
        .recv_val(recv_val), .recv_rdy(recv_rdy5), .recv_msg(recv_msg),
        .send_val(send_val5), .send_rdy(send_rdy), .send_msg(send_msg5),
        .cs(cs5), .sclk(sclk5), .mosi(mosi5), .miso(miso)
    );

    function automatic int eff_p(input int p);
        return (p == 0 || p > 34) ? 34 : p;
    endfunction

    function automatic int exp_lat(input int p, input int d);
        return 3 + 2 * p * (d + 1);
    endfunction

    function automatic logic [33:0] pmask(input int p);
        logic [33:0] one;
        one = 34'd1;
        return (p >= 34) ? {34{1'b1}} : ((one << p) - one);
    endfunction

    task automatic cfg(input int p, input int d, input int csa);
        @(negedge clk);
        ps_val = 1'b1; ps_msg = p[6:0];
        fq_val = 1'b1; fq_msg = d[7:0];
        csa_val = 1'b1; csa_msg = csa[2:0];
        @(posedge clk); #1;
        ps_val = 1'b0; fq_val = 1'b0; csa_val = 1'b0;
    endtask

    task automatic run_txn(input logic [33:0] msg, input int csa_exp, input int hold, input bit chk5,
                           input bit cfg_en, input int cp, input int cd, input int ccsa);
        logic [3:0] exp_cs;
        bit prev, got;
        o_lat = -1; o_rises = 0; o_high = 0; o_low = 0; o_mosi = '0; o_cs_err = 0; o_cs5_err = 0;
        o_hold_err = 0; o_io_err = 0; o_msg = '0; o_msg5 = '0; o_rdy_after = 0; o_val5 = 0; o_timeout = 0;
        exp_cs = 4'hF;
        if (csa_exp < 4) exp_cs[csa_exp[1:0]] = 1'b0;
        @(negedge clk);
        recv_val = 1'b1; recv_msg = msg;
        if (cfg_en) begin
            ps_val = 1'b1; ps_msg = cp[6:0];
            fq_val = 1'b1; fq_msg = cd[7:0];
            csa_val = 1'b1; csa_msg = ccsa[2:0];
        end
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (recv_rdy === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            o_timeout = 1; recv_val = 1'b0; ps_val = 1'b0; fq_val = 1'b0; csa_val = 1'b0;
            return;
        end
        @(posedge clk); #1;
        recv_val = 1'b0; ps_val = 1'b0; fq_val = 1'b0; csa_val = 1'b0;
        prev = 0;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (send_val === 1'b1) begin o_lat = c; break; end
            if (cs !== exp_cs) o_cs_err++;
            if (chk5 && cs5 !== 5'h1F) o_cs5_err++;
            if (sclk === 1'b1) o_high++; else o_low++;
            if (sclk === 1'b1 && !prev) begin o_rises++; o_mosi = {o_mosi[32:0], mosi}; end
            prev = (sclk === 1'b1);
        end
        if (o_lat < 0) begin o_timeout = 1; return; end
        if (cs !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0 || recv_rdy !== 1'b0) o_io_err++;
        o_msg = send_msg; o_val5 = send_val5; o_msg5 = send_msg5;
        repeat (hold) begin
            @(negedge clk);
            if (send_val !== 1'b1 || send_msg !== o_msg || recv_rdy !== 1'b0) o_hold_err++;
        end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        @(negedge clk);
        o_rdy_after = (recv_rdy === 1'b1 && send_val === 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({ps_rdy, csa_rdy, fq_rdy, recv_rdy} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_rdy_low: got %b want 0000", {ps_rdy, csa_rdy, fq_rdy, recv_rdy}); end
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (cs !== 4'hF) begin n_fail++; $display("FAIL reset_cs: got %b want 1111", cs); end
        n_chk++; if ({sclk, mosi, send_val} !== 3'b000) begin n_fail++;
            $display("FAIL reset_sclk_mosi_val: got %b want 000", {sclk, mosi, send_val}); end
        n_chk++; if (send_msg !== 34'd0) begin n_fail++; $display("FAIL reset_send_msg: got %h want 0", send_msg); end
        n_chk++; if ({ps_rdy, csa_rdy, fq_rdy, recv_rdy} !== 4'b1111) begin n_fail++;
            $display("FAIL idle_rdy: got %b want 1111", {ps_rdy, csa_rdy, fq_rdy, recv_rdy}); end
    endtask

    task automatic test_loopback_a5;
        cfg(8, 0, 2);
        loop_en = 1'b1;
        run_txn(34'hA5, 2, 0, 0, 0, 0, 0, 0);
        n_chk++; if (o_lat !== 19) begin n_fail++; $display("FAIL a5_latency: got %0d want 19", o_lat); end
        n_chk++; if (o_mosi !== 34'hA5) begin n_fail++; $display("FAIL a5_mosi_seq: got %h want a5", o_mosi); end
        n_chk++; if (o_msg !== 34'hA5) begin n_fail++; $display("FAIL a5_send_msg: got %h want a5", o_msg); end
        n_chk++; if (o_cs_err !== 0) begin n_fail++; $display("FAIL a5_cs2_only: got %0d bad cycles want 0", o_cs_err); end
        n_chk++; if (o_rises !== 8) begin n_fail++; $display("FAIL a5_rises: got %0d want 8", o_rises); end
        n_chk++; if (o_io_err !== 0) begin n_fail++; $display("FAIL a5_done_pins: got %0d want 0", o_io_err); end
    endtask

    task automatic test_long_miso_high;
        logic [33:0] m;
        m = {$urandom(), $urandom()};
        cfg(34, 3, 0);
        loop_en = 1'b0; miso_const = 1'b1;
        run_txn(m, 0, 5, 0, 0, 0, 0, 0);
        n_chk++; if (o_lat !== exp_lat(34, 3)) begin n_fail++; $display("FAIL long_latency: got %0d want %0d", o_lat, exp_lat(34, 3)); end
        n_chk++; if (o_high !== 34 * 4 || o_low !== 34 * 4 + 2) begin n_fail++;
            $display("FAIL long_sclk_periods: got high %0d low %0d want %0d %0d", o_high, o_low, 136, 138); end
        n_chk++; if (o_msg !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL long_send_msg: got %h want 3ffffffff", o_msg); end
        n_chk++; if (o_mosi !== m) begin n_fail++; $display("FAIL long_mosi: got %h want %h", o_mosi, m); end
        n_chk++; if (o_hold_err !== 0) begin n_fail++; $display("FAIL long_hold_stable: got %0d bad cycles want 0", o_hold_err); end
    endtask

    task automatic test_psize_clamp_cs_range;
        logic [33:0] m;
        m = {$urandom(), $urandom()};
        cfg(0, 0, 5);
        cfg(40, 0, 5);
        loop_en = 1'b1;
        run_txn(m, 1, 0, 1, 0, 0, 0, 0);
        n_chk++; if (o_rises !== 34) begin n_fail++; $display("FAIL clamp_rises: got %0d want 34", o_rises); end
        n_chk++; if (o_msg !== m) begin n_fail++; $display("FAIL clamp_send_msg: got %h want %h", o_msg, m); end
        n_chk++; if (o_cs5_err !== 0) begin n_fail++; $display("FAIL cs_out_of_range: got %0d cycles with a cs low want 0", o_cs5_err); end
        n_chk++; if (o_val5 !== 1'b1 || o_msg5 !== m) begin n_fail++;
            $display("FAIL cs_out_of_range_send: got val %b msg %h want 1 %h", o_val5, o_msg5, m); end
    endtask

    task automatic test_same_cycle_cfg;
        logic [33:0] m;
        m = {$urandom(), $urandom()};
        cfg(6, 0, 1);
        loop_en = 1'b1;
        run_txn(m, 1, 0, 0, 1, 10, 2, 3);
        n_chk++; if (o_lat !== exp_lat(6, 0) || o_cs_err !== 0) begin n_fail++;
            $display("FAIL cfg_old_used: got lat %0d cs_err %0d want %0d 0", o_lat, o_cs_err, exp_lat(6, 0)); end
        n_chk++; if (o_msg !== (m & pmask(6))) begin n_fail++; $display("FAIL cfg_old_msg: got %h want %h", o_msg, m & pmask(6)); end
        run_txn(m, 3, 0, 0, 0, 0, 0, 0);
        n_chk++; if (o_lat !== exp_lat(10, 2) || o_cs_err !== 0) begin n_fail++;
            $display("FAIL cfg_new_used: got lat %0d cs_err %0d want %0d 0", o_lat, o_cs_err, exp_lat(10, 2)); end
    endtask

    task automatic test_back_to_back;
        int p, d, csa;
        logic [33:0] m, exp_rx;
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(1, 34); d = $urandom_range(0, 3); csa = $urandom_range(0, 3);
            m = {$urandom(), $urandom()};
            loop_en = ($urandom_range(0, 1) == 1); miso_const = ($urandom_range(0, 1) == 1);
            exp_rx = loop_en ? (m & pmask(p)) : (miso_const ? pmask(p) : 34'd0);
            cfg(p, d, csa);
            run_txn(m, csa, $urandom_range(0, 2), 0, 0, 0, 0, 0);
            n_chk++; if (o_lat !== exp_lat(eff_p(p), d)) begin n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, o_lat, exp_lat(eff_p(p), d)); end
            n_chk++; if (o_msg !== exp_rx || o_mosi !== (m & pmask(p))) begin n_fail++;
                $display("FAIL b2b_data[%0d]: got rx %h mosi %h want %h %h", k, o_msg, o_mosi, exp_rx, m & pmask(p)); end
            n_chk++; if (o_cs_err !== 0 || o_io_err !== 0 || o_hold_err !== 0) begin n_fail++;
                $display("FAIL b2b_pins[%0d]: got %0d/%0d/%0d want 0/0/0", k, o_cs_err, o_io_err, o_hold_err); end
            n_chk++; if (o_rdy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_after_send[%0d]: got %b want 1", k, o_rdy_after); end
        end
    endtask

    task automatic test_reset_mid;
        int rises, bad;
        bit prev, got, reached;
        cfg(8, 1, 0);
        loop_en = 1'b1;
        @(negedge clk);
        recv_val = 1'b1; recv_msg = 34'hC3;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (recv_rdy === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        recv_val = 1'b0;
        rises = 0; prev = 0; reached = 0;
        for (int c = 0; c < 500 && got; c++) begin
            @(negedge clk);
            if (sclk === 1'b1 && !prev) rises++;
            prev = (sclk === 1'b1);
            if (rises == 3) begin reached = 1; break; end
        end
        n_chk++; if (!reached) begin n_fail++; $display("FAIL mid_reached_3rd_high: got %0d rises want 3", rises); end
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (cs !== 4'hF || sclk !== 1'b0 || send_val !== 1'b0 || recv_rdy !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_pins: got cs %b sclk %b val %b rdy %b want 1111 0 0 0", cs, sclk, send_val, recv_rdy); end
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (send_val !== 1'b0 || cs !== 4'hF || sclk !== 1'b0 || recv_rdy !== 1'b1) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL mid_after_reset_idle: got %0d bad cycles want 0", bad); end
        cfg(4, 0, 0);
        run_txn(34'h9, 0, 0, 0, 0, 0, 0, 0);
        n_chk++; if (o_msg !== 34'h9 || o_lat !== exp_lat(4, 0)) begin n_fail++;
            $display("FAIL mid_followup: got msg %h lat %0d want 9 %0d", o_msg, o_lat, exp_lat(4, 0)); end
    endtask

    initial begin
        reset = 1'b1; ps_val = 1'b0; csa_val = 1'b0; fq_val = 1'b0; recv_val = 1'b0; send_rdy = 1'b0;
        ps_msg = '0; csa_msg = '0; fq_msg = '0; recv_msg = '0; loop_en = 1'b0; miso_const = 1'b0;
        test_reset();
        test_loopback_a5();
        test_long_miso_high();
        test_psize_clamp_cs_range();
        test_same_cycle_cfg();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
